seg_scan_scheduler: RTL

//  Time-multiplexes the shared 7-bit segment bus LED[6:0] across the 3 digit selects LEDC[2:0].
//  A slot scheduler gives each digit one scan slot per frame.

---
 rtl/seg_scan_scheduler_pkg.sv | 42 ++++
 rtl/seg_scan_scheduler_slot_timer.sv | 47 ++++
 rtl/seg_scan_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/seg_scan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_scheduler_pkg
//  Brief    : Shared types, widths and load-word layout for the segment
//             scan scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package seg_scan_scheduler_pkg;

    localparam int c_NUM_DIGITS = 3;
    localparam int c_SEG_W      = 7;
    localparam int c_DATA_W     = c_NUM_DIGITS * c_SEG_W;
    localparam int c_DIGIT_W    = 2;

    // Bit offsets of each digit pattern inside load_data
    localparam int c_DIG0_LSB   = 0;
    localparam int c_DIG1_LSB   = c_SEG_W;
    localparam int c_DIG2_LSB   = 2 * c_SEG_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // Extract the segment pattern for one digit from a packed load word
    function automatic logic [c_SEG_W-1:0] unpack_digit(
        input logic [c_DATA_W-1:0]  data,
        input logic [c_DIGIT_W-1:0] idx
    );
        logic [c_SEG_W-1:0] seg;
        case (idx)
            2'd0:    seg = data[c_DIG0_LSB +: c_SEG_W];
            2'd1:    seg = data[c_DIG1_LSB +: c_SEG_W];
            2'd2:    seg = data[c_DIG2_LSB +: c_SEG_W];
            default: seg = '0;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_scheduler_slot_timer.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_scheduler_slot_timer
//  Brief    : Modulo-SLOT slot counter with clear; flags the last blank
//             cycle and the last cycle of a slot.
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_scheduler_slot_timer #(
    parameter int SLOT         = 10,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk30,
    input  logic rst,
    input  logic run_i,
    output logic at_blank_end_o,
    output logic at_slot_end_o
);

    localparam int c_CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(SLOT - 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign at_blank_end_o = (cnt_q == c_BLANK_LAST);
    assign at_slot_end_o  = (cnt_q == c_SLOT_LAST);

    // Count while running, wrap exactly at SLOT-1, hold at zero otherwise
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = at_slot_end_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_scheduler
//  Brief    : Multiplexes a 7-segment bus across 3 digit selects with a
//             guard blank per slot; double-buffered pattern load committed
//             only at frame boundaries (or immediately while idle).
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_scheduler
    import seg_scan_scheduler_pkg::*;
#(
    parameter int   CLK_HZ       = 30000000,
    parameter int   SCAN_HZ      = 1000,
    parameter int   BLANK_CYCLES = 300,
    parameter logic SEL_ON       = 1'b1
) (
    input  logic                clk30,
    input  logic                rst,
    input  logic                enable,
    input  logic                load_valid,
    input  logic [c_DATA_W-1:0] load_data,
    output logic                load_ready,
    output logic [c_SEG_W-1:0]  LED,
    output logic [2:0]          LEDC,
    output logic                frame_done
);

    localparam int c_SLOT = CLK_HZ / SCAN_HZ;
    localparam logic [c_DIGIT_W-1:0] c_LAST_DIGIT = c_DIGIT_W'(c_NUM_DIGITS - 1);

    state_t                 state_q, state_d;
    logic [c_DIGIT_W-1:0]   digit_q, digit_d;
    logic [c_DATA_W-1:0]    active_q, active_d;
    logic [c_DATA_W-1:0]    pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic [c_SEG_W-1:0]     led_q, led_d;
    logic [2:0]             ledc_q, ledc_d;
    logic                   frame_done_q, frame_done_d;

    logic w_run;
    logic w_at_blank_end;
    logic w_at_slot_end;
    logic w_accept;
    logic w_frame_end;
    logic w_commit;

    // The slot counter runs only while scanning; entering or leaving IDLE clears it
    assign w_run = (state_q != ST_IDLE) && enable;

    seg_scan_scheduler_slot_timer #(
        .SLOT         (c_SLOT),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk30          (clk30),
        .rst            (rst),
        .run_i          (w_run),
        .at_blank_end_o (w_at_blank_end),
        .at_slot_end_o  (w_at_slot_end)
    );

    assign load_ready = ~pend_full_q;
    assign LED        = led_q;
    assign LEDC       = ledc_q;
    assign frame_done = frame_done_q;

    // Next-state, buffer and registered-output logic
    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        led_d        = '0;
        ledc_d       = {3{~SEL_ON}};
        frame_done_d = 1'b0;

        w_accept    = load_valid && !pend_full_q;
        w_frame_end = (state_q == ST_SHOW) && (digit_q == c_LAST_DIGIT) && w_at_slot_end;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_BLANK;
                    digit_d = '0;
                end
            end
            ST_BLANK: begin
                if (w_at_blank_end) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (w_at_slot_end) begin
                    state_d = ST_BLANK;
                    digit_d = (digit_q == c_LAST_DIGIT) ? '0 : digit_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                digit_d = '0;
            end
        endcase

        // Dropping enable overrides everything and suppresses the frame pulse
        if (!enable) begin
            state_d = ST_IDLE;
            digit_d = '0;
        end

        frame_done_d = enable && w_frame_end;

        // Pending can never be both committed and refilled on the same edge,
        // since ready is low whenever pending holds data
        w_commit = pend_full_q && ((state_q == ST_IDLE) || (enable && w_frame_end));
        if (w_commit) begin
            active_d    = pend_q;
            pend_full_d = 1'b0;
        end
        if (w_accept) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end

        if (state_d == ST_SHOW) begin
            led_d = unpack_digit(active_d, digit_d);
            for (int i = 0; i < c_NUM_DIGITS; i++) begin
                if (digit_d == c_DIGIT_W'(i)) begin
                    ledc_d[i] = SEL_ON;
                end
            end
        end
    end

    // State, buffers and output registers
    always_ff @(posedge clk30 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            digit_q      <= '0;
            active_q     <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            led_q        <= '0;
            ledc_q       <= {3{~SEL_ON}};
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            led_q        <= led_d;
            ledc_q       <= ledc_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule
`default_nettype wire
